matrix_scan_driver: RTL and testbench

MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

---
 rtl/matrix_pkg.sv | 19 +
 rtl/matrix_scan_driver_if.sv | 29 ++
 rtl/matrix_tick.sv | 26 ++
 rtl/matrix_scan_driver.sv | 173 +++++++++++++++++
 tb/tb_matrix_scan_driver.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// rtl/matrix_pkg.sv - shared scan types and pixel constants; MATRIX_PWM_EN selects 2-bit pixels and 3 subframes
package matrix_pkg;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_SETUP = 2'd1,
        ST_CLKHI = 2'd2,
        ST_LATCH = 2'd3
    } scan_state_t;

`ifdef MATRIX_PWM_EN
    localparam int PIX_W     = 2;
    localparam int SUBFRAMES = 3;
`else
    localparam int PIX_W     = 1;
    localparam int SUBFRAMES = 1;
`endif

endpackage

// File: rtl/matrix_scan_driver_if.sv
// rtl/matrix_scan_driver_if.sv - pixel write and buffer swap port; pixel width follows MATRIX_PWM_EN
interface matrix_scan_driver_if
    import matrix_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8
);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);

    logic             wr_en;
    logic [RW-1:0]    wr_row;
    logic [CW-1:0]    wr_col;
    logic [PIX_W-1:0] wr_red;
    logic [PIX_W-1:0] wr_green;
    logic             swap_req;
    logic             swap_ack;

    modport master (
        output wr_en, wr_row, wr_col, wr_red, wr_green, swap_req,
        input  swap_ack
    );

    modport slave (
        input  wr_en, wr_row, wr_col, wr_red, wr_green, swap_req,
        output swap_ack
    );

endinterface

// File: rtl/matrix_tick.sv
// rtl/matrix_tick.sv - one-clk tick every DIV clk cycles
module matrix_tick #(
    parameter int DIV = 2700
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] cnt;

    // free-running divider, restarted by reset so the first tick lands DIV clks after release
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DIV - 1)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tick = (cnt == CNT_W'(DIV - 1));

endmodule

// File: rtl/matrix_scan_driver.sv
// rtl/matrix_scan_driver.sv - double-buffered LED matrix scanner; MATRIX_PWM_EN adds 3-subframe 4-level PWM
module matrix_scan_driver
    import matrix_pkg::*;
#(
    parameter int ROWS = 8,
    parameter int COLS = 8,
    parameter int DIV  = 2700
) (
    input  logic                 clk,
    input  logic                 rst,
    matrix_scan_driver_if.slave  bus,
    output logic                 mat_CLOCK,
    output logic                 mat_RCLOCK,
    output logic                 ROW,
    output logic                 COL_Red,
    output logic                 COL_Green,
    output logic                 CLR,
    output logic                 frame_start
);
    localparam int N  = (ROWS > COLS) ? ROWS : COLS;
    localparam int RW = $clog2(ROWS);
    localparam int KW = $clog2(N);

    logic tick;

    matrix_tick #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    scan_state_t   state_q, state_n;
    logic [RW-1:0] row_q, row_n;
    logic [KW-1:0] k_q, k_n;
    logic          bank_q, bank_n;
    logic          fs_q, fs_n;
    logic          clr_q;
    logic          swap_now;
    logic          last_sub;
`ifdef MATRIX_PWM_EN
    logic [1:0]    sub_q, sub_n;
    assign last_sub = (sub_q == 2'(SUBFRAMES - 1));
`else
    assign last_sub = 1'b1;
`endif

    logic [PIX_W-1:0] red_mem [2][ROWS][COLS];
    logic [PIX_W-1:0] grn_mem [2][ROWS][COLS];
    logic [PIX_W-1:0] pix_r, pix_g;
    logic             lit_r, lit_g, in_cols;

    // pixel writes always target the bank not being displayed; contents survive reset
    always_ff @(posedge clk) begin
        if (bus.wr_en && int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS) begin
            red_mem[~bank_q][bus.wr_row][bus.wr_col] <= bus.wr_red;
            grn_mem[~bank_q][bus.wr_row][bus.wr_col] <= bus.wr_green;
        end
    end

    // scan state register; CLR releases on the first clk after reset drops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            row_q   <= '0;
            k_q     <= '0;
            bank_q  <= 1'b0;
            fs_q    <= 1'b0;
            clr_q   <= 1'b0;
`ifdef MATRIX_PWM_EN
            sub_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_n;
            row_q   <= row_n;
            k_q     <= k_n;
            bank_q  <= bank_n;
            fs_q    <= fs_n;
            clr_q   <= 1'b1;
`ifdef MATRIX_PWM_EN
            sub_q   <= sub_n;
`endif
        end
    end

    // next-state: one state step per tick; frame wrap handles frame_start and the bank swap
    always_comb begin
        state_n  = state_q;
        row_n    = row_q;
        k_n      = k_q;
        bank_n   = bank_q;
        fs_n     = 1'b0;
        swap_now = 1'b0;
`ifdef MATRIX_PWM_EN
        sub_n    = sub_q;
`endif
        if (tick && !rst) begin
            case (state_q)
                ST_RESET: begin
                    state_n = ST_SETUP;
                    fs_n    = 1'b1;
                end
                ST_SETUP: state_n = ST_CLKHI;
                ST_CLKHI: begin
                    if (k_q == KW'(N - 1)) begin
                        state_n = ST_LATCH;
                    end else begin
                        state_n = ST_SETUP;
                        k_n     = k_q + KW'(1);
                    end
                end
                ST_LATCH: begin
                    state_n = ST_SETUP;
                    k_n     = '0;
                    if (row_q == RW'(ROWS - 1)) begin
                        row_n = '0;
                        if (last_sub) begin
                            fs_n = 1'b1;
                            if (bus.swap_req) begin
                                bank_n   = ~bank_q;
                                swap_now = 1'b1;
                            end
                        end
`ifdef MATRIX_PWM_EN
                        sub_n = last_sub ? 2'd0 : sub_q + 2'd1;
`endif
                    end else begin
                        row_n = row_q + RW'(1);
                    end
                end
                default: state_n = ST_RESET;
            endcase
        end
    end

    // front-bank pixel at the current shift step
    always_comb begin
        pix_r   = '0;
        pix_g   = '0;
        in_cols = (int'(k_q) < COLS);
        for (int c = 0; c < COLS; c++) begin
            if (int'(k_q) == c) begin
                pix_r = red_mem[bank_q][row_q][c];
                pix_g = grn_mem[bank_q][row_q][c];
            end
        end
`ifdef MATRIX_PWM_EN
        lit_r = (pix_r > sub_q);
        lit_g = (pix_g > sub_q);
`else
        lit_r = pix_r[0];
        lit_g = pix_g[0];
`endif
    end

    // shift-chain pins decoded from state; data held constant across SETUP and CLKHI
    always_comb begin
        mat_CLOCK  = (state_q == ST_CLKHI);
        mat_RCLOCK = (state_q == ST_LATCH);
        ROW        = 1'b0;
        COL_Red    = 1'b1;
        COL_Green  = 1'b1;
        if (state_q != ST_RESET) begin
            ROW       = (int'(k_q) == int'(row_q));
            COL_Red   = in_cols ? ~lit_r : 1'b1;
            COL_Green = in_cols ? ~lit_g : 1'b1;
        end
    end

    assign CLR          = clr_q;
    assign frame_start  = fs_q;
    assign bus.swap_ack = swap_now;

endmodule

// File: tb/tb_matrix_scan_driver.sv
// tb/tb_matrix_scan_driver.sv - scoreboard bench for matrix_scan_driver (8x8 and 4x6), MATRIX_PWM_EN aware
module tb_matrix_scan_driver;
    import matrix_pkg::*;

    localparam int DIVB = 2;
`ifdef MATRIX_PWM_EN
    localparam int NSUB = 3;
    localparam int MAXL = 3;
`else
    localparam int NSUB = 1;
    localparam int MAXL = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matrix_scan_driver_if #(.ROWS(8), .COLS(8)) bus8 ();
    matrix_scan_driver_if #(.ROWS(4), .COLS(6)) bus46 ();

    logic clk8, rclk8, row8, cr8, cg8, clr8, fs8;
    logic clk46, rclk46, row46, cr46, cg46, clr46, fs46;

    matrix_scan_driver #(.ROWS(8), .COLS(8), .DIV(DIVB)) u_dut8 (
        .clk(clk), .rst(rst), .bus(bus8),
        .mat_CLOCK(clk8), .mat_RCLOCK(rclk8), .ROW(row8),
        .COL_Red(cr8), .COL_Green(cg8), .CLR(clr8), .frame_start(fs8)
    );

    matrix_scan_driver #(.ROWS(4), .COLS(6), .DIV(DIVB)) u_dut46 (
        .clk(clk), .rst(rst), .bus(bus46),
        .mat_CLOCK(clk46), .mat_RCLOCK(rclk46), .ROW(row46),
        .COL_Red(cr46), .COL_Green(cg46), .CLR(clr46), .frame_start(fs46)
    );

    int checks = 0;
    int errors = 0;
    int mr [2][8][8];
    int mg [2][8][8];
    logic [2:0] sbq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit lit(input int lvl, input int s);
`ifdef MATRIX_PWM_EN
        return lvl > s;
`else
        return (lvl != 0) && (s >= 0);
`endif
    endfunction

    task automatic pins(input int sel, output logic [7:0] v);
        if (sel == 0) v = {clk8, rclk8, row8, cr8, cg8, fs8, clr8, bus8.swap_ack};
        else          v = {clk46, rclk46, row46, cr46, cg46, fs46, clr46, bus46.swap_ack};
    endtask

    task automatic wr_pix(input int sel, input int r, input int c, input int red, input int grn);
        if (sel == 0) begin
            bus8.wr_en = 1'b1; bus8.wr_row = r[2:0]; bus8.wr_col = c[2:0];
            bus8.wr_red = red[PIX_W-1:0]; bus8.wr_green = grn[PIX_W-1:0];
        end else begin
            bus46.wr_en = 1'b1; bus46.wr_row = r[1:0]; bus46.wr_col = c[2:0];
            bus46.wr_red = red[PIX_W-1:0]; bus46.wr_green = grn[PIX_W-1:0];
        end
        mr[sel][r][c] = red;
        mg[sel][r][c] = grn;
        @(negedge clk);
        bus8.wr_en  = 1'b0;
        bus46.wr_en = 1'b0;
    endtask

    task automatic push_frame(input int sel);
        int rows, cols, n;
        rows = (sel == 0) ? 8 : 4;
        cols = (sel == 0) ? 8 : 6;
        n    = (rows > cols) ? rows : cols;
        for (int s = 0; s < NSUB; s++)
            for (int r = 0; r < rows; r++)
                for (int k = 0; k < n; k++)
                    sbq.push_back({(k == r) && (k < rows),
                                   (k < cols) ? !lit(mr[sel][r][k], s) : 1'b1,
                                   (k < cols) ? !lit(mg[sel][r][k], s) : 1'b1});
    endtask

    // called at the negedge where frame_start is high; consumes exactly one frame
    task automatic capture(input int sel, input string tag);
        int rows, n, total, rises, last, latches, idx, acks;
        logic [7:0] v;
        logic prev;
        logic [2:0] exp;
        rows = (sel == 0) ? 8 : 4;
        n    = (sel == 0) ? 8 : 6;
        total = NSUB * rows * (2 * n + 1) * DIVB;
        prev = 1'b0; rises = 0; last = -1; latches = 0; idx = 0; acks = 0;
        for (int i = 0; i < total; i++) begin
            if (i > 0) @(negedge clk);
            pins(sel, v);
            if (i == 0) check({tag, " fs_first"}, 32'(v[2]), 32'd1);
            if (i == 1) check({tag, " fs_pulse"}, 32'(v[2]), 32'd0);
            if (v[0]) acks++;
            if (v[7] && !prev) begin
                exp = (sbq.size() > 0) ? sbq.pop_front() : 3'b000;
                check($sformatf("%s data idx%0d", tag, idx), 32'(v[5:3]), 32'(exp));
                rises++;
                idx++;
            end
            if (v[6] && (i == 0 || !rclk_prev(sel, v, i))) begin
                check({tag, " clks_per_row"}, 32'(rises), 32'(n));
                if (last >= 0) check({tag, " row_ticks"}, 32'(i - last), 32'((2 * n + 1) * DIVB));
                rises = 0;
                last = i;
                latches++;
            end
            prev = v[7];
            rclk_hist = v[6];
        end
        check({tag, " latches"}, 32'(latches), 32'(NSUB * rows));
        check({tag, " no_ack_in_frame"}, 32'(acks), 32'd0);
        check({tag, " sb_empty"}, 32'(sbq.size()), 32'd0);
    endtask

    logic rclk_hist = 1'b0;
    function automatic bit rclk_prev(input int sel, input logic [7:0] v, input int i);
        return rclk_hist && (sel >= 0) && (v[6] || i >= 0);
    endfunction

    task automatic wait_fs(input int sel, input int limit, input string tag);
        logic [7:0] v;
        int found;
        found = 0;
        for (int i = 0; i < limit && found == 0; i++) begin
            @(negedge clk);
            pins(sel, v);
            if (v[2]) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_ack(input int sel, input int limit, input string tag);
        logic [7:0] v;
        int found;
        found = 0;
        for (int i = 0; i < limit && found == 0; i++) begin
            @(negedge clk);
            pins(sel, v);
            if (v[0]) found = 1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        logic [7:0] v;
        int acks, found;
        rst = 1'b1;
        bus8.wr_en = 1'b0; bus8.wr_row = '0; bus8.wr_col = '0;
        bus8.wr_red = '0; bus8.wr_green = '0; bus8.swap_req = 1'b0;
        bus46.wr_en = 1'b0; bus46.wr_row = '0; bus46.wr_col = '0;
        bus46.wr_red = '0; bus46.wr_green = '0; bus46.swap_req = 1'b0;

        // reset state
        repeat (3) @(negedge clk);
        check("rst mat_CLOCK", 32'(clk8), 32'd0);
        check("rst mat_RCLOCK", 32'(rclk8), 32'd0);
        check("rst ROW", 32'(row8), 32'd0);
        check("rst COL_Red", 32'(cr8), 32'd1);
        check("rst COL_Green", 32'(cg8), 32'd1);
        check("rst CLR", 32'(clr8), 32'd0);
        check("rst frame_start", 32'(fs8), 32'd0);
        check("rst swap_ack", 32'(bus8.swap_ack), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("CLR after release", 32'(clr8), 32'd1);
        wait_fs(0, 10, "first frame_start");

        // pattern 1 into back bank, then swap at the frame boundary
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                wr_pix(0, r, c, (r == 0) ? ((c < 4) ? MAXL : 0) : ((r * 5 + c * 3) % (MAXL + 1)),
                       (r + 2 * c) % (MAXL + 1));
        bus8.swap_req = 1'b1;
        wait_ack(0, 1200, "swap1 ack seen");
        check("swap1 ack in LATCH", 32'(rclk8), 32'd1);
        @(negedge clk);
        bus8.swap_req = 1'b0;
        check("swap1 ack one clk", 32'(bus8.swap_ack), 32'd0);
        push_frame(0);
        capture(0, "frame1");

        // pattern 2; pixel (2,3) rewritten on the very clk of the swap
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                wr_pix(0, r, c, (r * 7 + c * 2) % (MAXL + 1), (r * c + 1) % (MAXL + 1));
        bus8.swap_req = 1'b1;
        wait_ack(0, 1200, "swap2 ack seen");
        wr_pix(0, 2, 3, MAXL, 0);
        bus8.swap_req = 1'b0;
        push_frame(0);
        capture(0, "frame2");

        // short swap request inside a frame is dropped
        repeat (20) @(negedge clk);
        bus8.swap_req = 1'b1;
        repeat (5) @(negedge clk);
        bus8.swap_req = 1'b0;
        acks = 0; found = 0;
        for (int i = 0; i < 1200 && found == 0; i++) begin
            @(negedge clk);
            pins(0, v);
            if (v[0]) acks++;
            if (v[2]) found = 1;
        end
        check("dropped req frame_start", 32'(found), 32'd1);
        check("dropped req no ack", 32'(acks), 32'd0);
        push_frame(0);
        capture(0, "frame3");

        // reset in the middle of CLKHI
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            @(negedge clk);
            if (clk8) found = 1;
        end
        check("reached CLKHI", 32'(found), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst mat_CLOCK", 32'(clk8), 32'd0);
        check("midrst mat_RCLOCK", 32'(rclk8), 32'd0);
        check("midrst COL_Red", 32'(cr8), 32'd1);
        check("midrst COL_Green", 32'(cg8), 32'd1);
        check("midrst ROW", 32'(row8), 32'd0);
        check("midrst CLR", 32'(clr8), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        wait_fs(0, 10, "frame_start after midrst");
        push_frame(0);
        capture(0, "frame4");

        // 4x6 matrix: N=6, ROW never set at k=4,5
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 6; c++)
                wr_pix(1, r, c, (r * 2 + c) % (MAXL + 1), (r + c * 3 + 1) % (MAXL + 1));
        bus46.swap_req = 1'b1;
        wait_ack(1, 600, "swap46 ack seen");
        @(negedge clk);
        bus46.swap_req = 1'b0;
        push_frame(1);
        capture(1, "frame46");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
